// File: rtl/layer_sel_ctrl.sv
// Layer select controller: double-buffered sprite positions plus a two-stage
// pixel pipeline that picks the visible layer (sprite or map tile) and the
// pixel offset inside the selected 32x32 image.
module layer_sel_ctrl #(
  parameter int unsigned TILE_LOG2 = 5
) (
  input  logic                     i_pclk,
  input  logic                     i_rst,
  input  logic [10:0]              i_hcount,
  input  logic [10:0]              i_vcount,
  input  logic                     i_hblnk,
  input  logic                     i_vblnk,
  input  logic                     i_pos_vld,
  input  logic [21:0]              i_plr1_xy,
  input  logic [21:0]              i_plr2_xy,
  input  logic [21:0]              i_bomb_xy,
  input  logic [21:0]              i_expl_xy,
  input  logic [3:0]               i_spr_en,
  output logic [9:0]               o_map_addr,
  input  logic [1:0]               i_map_data,
  output logic [2:0]               o_sel,
  output logic [2*TILE_LOG2-1:0]   o_rom_addr,
  output logic                     o_hblnk,
  output logic                     o_vblnk,
  output logic                     o_frame_upd
);

  localparam int unsigned OFFW = 2 * TILE_LOG2;
  localparam logic [11:0] TILE = 12'(1) << TILE_LOG2;

  typedef enum logic [2:0] {
    SEL_PATH = 3'b000,
    SEL_OBS1 = 3'b001,
    SEL_OBS2 = 3'b010,
    SEL_BOMB = 3'b011,
    SEL_EXPL = 3'b100,
    SEL_PLR1 = 3'b101,
    SEL_PLR2 = 3'b110,
    SEL_NONE = 3'b111
  } sel_e;

  // Sprite index matches the i_spr_en bit: 0 bomb, 1 expl, 2 plr2, 3 plr1.
  logic [21:0]     in_xy   [4];
  logic [21:0]     pend_xy [4];
  logic [21:0]     shd_xy  [4];
  logic [3:0]      pend_en;
  logic [3:0]      shd_en;
  logic            pend_flag;
  logic            vblnk_prev;
  logic            vb_start;

  logic [11:0]     hc;
  logic [11:0]     vc;
  logic [3:0]      hit;
  logic [OFFW-1:0] spr_off [4];

  logic [3:0]      s1_hit;
  logic [OFFW-1:0] s1_off  [4];
  logic [OFFW-1:0] s1_toff;
  logic            s1_hblnk;
  logic            s1_vblnk;

  sel_e            nxt_sel;
  logic [OFFW-1:0] nxt_rom;

  assign vb_start = i_vblnk & ~vblnk_prev;
  assign hc       = {1'b0, i_hcount};
  assign vc       = {1'b0, i_vcount};

  // Gather sprite position inputs into an indexable array
  always_comb begin
    in_xy[0] = i_bomb_xy;
    in_xy[1] = i_expl_xy;
    in_xy[2] = i_plr2_xy;
    in_xy[3] = i_plr1_xy;
  end

  // Pending/shadow position registers; shadow only moves at vblank start.
  // A strobe coinciding with vblank start goes straight to shadow, leaving
  // the pending flag clear so the next vblank does not update again.
  always_ff @(posedge i_pclk) begin
    if (!i_rst) begin
      vblnk_prev  <= 1'b1;
      pend_en     <= '0;
      pend_flag   <= 1'b0;
      shd_en      <= '0;
      o_frame_upd <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        pend_xy[i] <= '0;
        shd_xy[i]  <= '0;
      end
    end else begin
      vblnk_prev  <= i_vblnk;
      o_frame_upd <= 1'b0;
      if (i_pos_vld) begin
        pend_en <= i_spr_en;
        for (int unsigned i = 0; i < 4; i++) pend_xy[i] <= in_xy[i];
      end
      if (vb_start) begin
        pend_flag <= 1'b0;
        if (i_pos_vld) begin
          shd_en      <= i_spr_en;
          o_frame_upd <= 1'b1;
          for (int unsigned i = 0; i < 4; i++) shd_xy[i] <= in_xy[i];
        end else if (pend_flag) begin
          shd_en      <= pend_en;
          o_frame_upd <= 1'b1;
          for (int unsigned i = 0; i < 4; i++) shd_xy[i] <= pend_xy[i];
        end
      end else if (i_pos_vld) begin
        pend_flag <= 1'b1;
      end
    end
  end

  // Per-sprite hit test and image offset; 12-bit math keeps x+32 from wrapping
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [11:0] sx, sy, dx, dy;
      sx = {1'b0, shd_xy[i][21:11]};
      sy = {1'b0, shd_xy[i][10:0]};
      dx = hc - sx;
      dy = vc - sy;
      hit[i] = shd_en[i] && (hc >= sx) && (hc < sx + TILE)
                         && (vc >= sy) && (vc < sy + TILE);
      spr_off[i] = {dy[TILE_LOG2-1:0], dx[TILE_LOG2-1:0]};
    end
  end

  // Stage 1: map address, hits, offsets and blanking
  always_ff @(posedge i_pclk) begin
    if (!i_rst) begin
      o_map_addr <= '0;
      s1_hit     <= '0;
      s1_toff    <= '0;
      s1_hblnk   <= 1'b1;
      s1_vblnk   <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) s1_off[i] <= '0;
    end else begin
      o_map_addr <= {i_vcount[TILE_LOG2+4:TILE_LOG2], i_hcount[TILE_LOG2+4:TILE_LOG2]};
      s1_hit     <= hit;
      s1_toff    <= {i_vcount[TILE_LOG2-1:0], i_hcount[TILE_LOG2-1:0]};
      s1_hblnk   <= i_hblnk;
      s1_vblnk   <= i_vblnk;
      for (int unsigned i = 0; i < 4; i++) s1_off[i] <= spr_off[i];
    end
  end

  // Fixed-priority layer pick: plr1 > plr2 > expl > bomb > map tile
  always_comb begin
    nxt_sel = SEL_NONE;
    nxt_rom = '0;
    if (!(s1_hblnk || s1_vblnk)) begin
      if (s1_hit[3]) begin
        nxt_sel = SEL_PLR1;
        nxt_rom = s1_off[3];
      end else if (s1_hit[2]) begin
        nxt_sel = SEL_PLR2;
        nxt_rom = s1_off[2];
      end else if (s1_hit[1]) begin
        nxt_sel = SEL_EXPL;
        nxt_rom = s1_off[1];
      end else if (s1_hit[0]) begin
        nxt_sel = SEL_BOMB;
        nxt_rom = s1_off[0];
      end else begin
        case (i_map_data)
          2'd0: begin nxt_sel = SEL_PATH; nxt_rom = s1_toff; end
          2'd1: begin nxt_sel = SEL_OBS1; nxt_rom = s1_toff; end
          2'd2: begin nxt_sel = SEL_OBS2; nxt_rom = s1_toff; end
          default: begin nxt_sel = SEL_NONE; nxt_rom = '0; end
        endcase
      end
    end
  end

  // Stage 2: registered select, ROM address and aligned blanking
  always_ff @(posedge i_pclk) begin
    if (!i_rst) begin
      o_sel      <= SEL_NONE;
      o_rom_addr <= '0;
      o_hblnk    <= 1'b1;
      o_vblnk    <= 1'b1;
    end else begin
      o_sel      <= nxt_sel;
      o_rom_addr <= nxt_rom;
      o_hblnk    <= s1_hblnk;
      o_vblnk    <= s1_vblnk;
    end
  end

endmodule

// File: doc/layer_sel_ctrl.md
LAYER_SEL_CTRL -- requirements
Module: layer_sel_ctrl

Interface
REQ-001 SHALL have parameter TILE_LOG2, default 5, meaning log2 of tile and sprite edge in pixels (32x32).
REQ-002 SHALL have port i_pclk  in  1  pixel clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  in  1  synchronous, active-low reset (0 = reset), sampled on i_pclk.
REQ-004 SHALL have ports i_hcount, i_vcount  in  11 each  current pixel coordinates.
REQ-005 SHALL have ports i_hblnk, i_vblnk  in  1 each  blanking flags aligned with the counts.
REQ-006 SHALL have port i_pos_vld  in  1  one-cycle strobe: sprite positions/enables valid.
REQ-007 SHALL have ports i_plr1_xy, i_plr2_xy, i_bomb_xy, i_expl_xy  in  22 each  {x[10:0], y[10:0]} top-left corner.
REQ-008 SHALL have port i_spr_en  in  4  enables {plr1, plr2, expl, bomb}, bit 3 = plr1.
REQ-009 SHALL have port o_map_addr  out  10  tile-map address {vcount[9:5], hcount[9:5]}.
REQ-010 SHALL have port i_map_data  in  2  tile type, valid one cycle after o_map_addr: 0 path, 1 obs1, 2 obs2, 3 reserved.
REQ-011 SHALL have port o_sel  out  3  layer select for the rgb mux: 000 path, 001 obs1, 010 obs2, 011 bomb, 100 expl, 101 plr1, 110 plr2, 111 none.
REQ-012 SHALL have port o_rom_addr  out  10  {row[4:0], col[4:0]} pixel offset inside the selected 32x32 image.
REQ-013 SHALL have ports o_hblnk, o_vblnk  out  1 each  blanking delayed to align with o_sel.
REQ-014 SHALL have port o_frame_upd  out  1  one-cycle pulse when shadow positions are updated.

Function
REQ-015 SHALL hold a pending register set (4 positions + enables) and a pending flag; i_pos_vld=1 loads pending from inputs and sets the flag, with the latest strobe overwriting earlier ones.
REQ-016 SHALL detect vblank start as i_vblnk=1 with the registered previous i_vblnk=0.
REQ-017 At vblank start with the pending flag set, SHALL copy pending into the shadow set, clear the flag, and pulse o_frame_upd the next cycle.
REQ-018 At vblank start with i_pos_vld=1 in the same cycle, SHALL load shadow directly from the inputs, leave the flag cleared, and pulse o_frame_upd.
REQ-019 At vblank start with no pending flag and no strobe, shadow SHALL be unchanged and o_frame_upd SHALL stay 0.
REQ-020 Hit compare and ROM-address generation SHALL use only shadow values; shadow SHALL never change outside vblank start.
REQ-021 Stage 1: SHALL register o_map_addr, per-sprite hit flags, per-sprite offsets, tile offsets {vcount[4:0], hcount[4:0]}, and blanking.
REQ-022 A sprite SHALL hit when enabled and x <= hcount < x+32 and y <= vcount < y+32, using 12-bit sums so that x+32 never wraps.
REQ-023 A sprite offset SHALL be {(vcount-y)[4:0], (hcount-x)[4:0]}.
REQ-024 Stage 2: SHALL register o_sel/o_rom_addr by fixed priority plr1 > plr2 > expl > bomb > map tile, where map tile = i_map_data mapped per REQ-010.
REQ-025 i_map_data=3 with no sprite hit SHALL yield o_sel=111 and o_rom_addr=0.
REQ-026 With stage-1 blanking set (h or v), stage 2 SHALL output o_sel=111 and o_rom_addr=0 regardless of hits.
REQ-027 Latency SHALL be exactly 2 cycles from i_hcount/i_vcount/blanking to o_sel, o_rom_addr, o_hblnk and o_vblnk; o_map_addr SHALL have 1 cycle.
REQ-028 Throughput SHALL be one pixel per cycle with no stalls.

Reset
REQ-029 While i_rst=0 at a clock edge, all outputs SHALL become 0 except o_sel=111, and o_hblnk and o_vblnk SHALL become 1.
REQ-030 Reset SHALL clear shadow enables, pending enables and the pending flag, so no sprite hits until the first post-reset update.
REQ-031 Reset asserted mid-frame SHALL discard pipeline contents; the first valid o_sel SHALL appear 2 cycles after release.

Verification
REQ-032 Update then vblank: strobe plr1 at (100,100) enabled at line 50, vblank rises at line 600 -> o_frame_upd one cycle; next frame pixel (100,100) gives o_sel=101, o_rom_addr=0, and (131,131) gives o_rom_addr=0x3FF.
REQ-033 Priority overlap: plr1, plr2 and bomb all at (200,200) -> o_sel=101; disable plr1 -> 110; disable plr2 -> 011; disable bomb, i_map_data=1 -> 001.
REQ-034 Edge and wrap: sprite at x=1010 -> hcount 1041 hits, hcount 1042 misses, and no hit at hcount 0-9.
REQ-035 Simultaneous event: i_pos_vld on the exact vblank-rise cycle with a different pending value -> shadow = strobe value, flag cleared, single o_frame_upd.
REQ-036 Blanking and latency: any hit with i_hblnk=1 -> o_sel=111 two cycles later, and o_hblnk matches i_hblnk delayed 2 cycles.
REQ-037 Mid-frame reset: pulse i_rst=0 for 1 cycle during active video -> o_sel=111 for that cycle and the following 2 cycles, then map-only selection with sprites disabled.
